timer_alarm_sched: RTL and testbench
====================================

Name: timer_alarm_sched

Overview:
- Shares one free-running timestamp counter among CH_NUM software alarm slots.
- Each slot is armed with a relative delay, counted in prescaled ticks, and raises a sticky fire flag when its deadline passes.
- Sits beside the APB timer: its tick_i comes from the timer's prescaled clock-enable. A bus wrapper drives the arm, cancel and ack ports.
- Uses a round-robin expiry scanner, not N parallel comparators, to save area.

Parameters:
- CH_NUM, 4, number of alarm slots (power of two, 2..16).
- CNT_WIDTH, 32, timestamp and delay width in bits.

Ports:
- clk_i  in  1  block clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- tick_i  in  1  single-cycle timebase enable (prescaled tick).
- arm_valid_i  in  1  arm request valid.
- arm_ready_o  out  1  arm request accepted this cycle.
- arm_ch_i  in  $clog2(CH_NUM)  target slot.
- arm_dly_i  in  CNT_WIDTH  delay in ticks.
- cancel_i  in  CH_NUM  per-slot cancel pulse.
- ack_i  in  CH_NUM  per-slot fire acknowledge pulse.
- busy_o  out  CH_NUM  slot armed, not yet expired.
- fire_o  out  CH_NUM  sticky expiry flag.
- irq_o  out  1  OR of fire_o.
- now_o  out  CNT_WIDTH  current timestamp.

Behaviour:
- Reset: now_o=0, busy_o=0, fire_o=0, irq_o=0, scan pointer=0, all deadlines=0. Reset mid-operation discards all armed slots immediately.
- Timestamp: now increments by 1 on each cycle with tick_i=1. It wraps modulo 2^CNT_WIDTH with no flag.
- Arm handshake:
  - arm_ready_o = ~busy_o[arm_ch_i], combinational.
  - Accept when arm_valid_i && arm_ready_o. Next cycle: busy[ch]=1 and deadline[ch] = now + eff_dly.
  - eff_dly = max(arm_dly_i,1), then min(eff_dly, 2^(CNT_WIDTH-1)-1). The clamp guarantees the wrap-safe compare below.
  - "now" in the deadline sum is the pre-increment value if tick_i=1 in the same cycle.
  - Arming is allowed while fire_o[ch]=1; fire_o is unchanged by arming.
- Expiry test for slot p: busy[p] && MSB(now - deadline[p]) == 0, using CNT_WIDTH-bit subtraction (signed difference >= 0). This is correct across timestamp wrap.
- Scanner FSM:
  - States IDLE and SCAN. IDLE when busy_o==0; SCAN otherwise.
  - In SCAN the pointer advances by 1 (mod CH_NUM) every cycle. It holds in IDLE.
  - Each cycle, slot[ptr] is tested. On expiry, next cycle: busy[ptr]=0, fire[ptr]=1.
  - Latency: fire_o[p] rises 1..CH_NUM cycles after the cycle in which now first equals deadline[p].
- Cancel: cancel_i[p] clears busy[p] next cycle, with no fire.
  - Cancel beats a same-cycle expiry of p.
  - Cancel of an idle slot has no effect.
  - Cancel does not clear fire_o.
- Ack: ack_i[p] clears fire[p] next cycle. A same-cycle new expiry of p wins, so fire stays 1.
- Simultaneous arm plus cancel on the same slot: the arm is never accepted, because arm_ready_o is low while busy; the cancel applies.
- irq_o is registered: irq_o = |fire_o, with the same timing as fire_o.

Optional Feature:
- Macro TIMER_SCHED_PERIODIC_EN.
- Defined:
  - Adds input arm_per_i (1 bit), sampled with arm.
  - Each slot stores eff_dly as its period plus a periodic bit.
  - On expiry of a periodic slot: fire[p]=1, busy stays 1, deadline[p] += period.
  - Only cancel ends a periodic slot.
- Not defined: port absent; all slots are one-shot as above.

Test Plan:
- Single one-shot: tick every cycle; arm ch0 delay 10 at now=5. Required: deadline 15; fire_o[0] rises between the cycles where now_o=15 and now_o=15+4; busy_o[0] falls in the same cycle; irq_o=1. Then ack_i[0] clears both fire_o[0] and irq_o next cycle.
- Wrap: force now near 2^32-3; arm ch1 delay 6. Required: fire occurs after now wraps to 3, not earlier.
- All four slots armed with delays 4,4,4,4 in consecutive cycles. Required: all fire within 4 cycles of their deadlines, in pointer order. Arm of a busy slot: arm_ready_o=0 and the request is held off until expiry.
- Cancel races expiry: cancel ch2 in the cycle its expiry is scanned. Required: busy_o[2]=0 next cycle, fire_o[2] stays 0. A separate same-cycle ack plus re-expiry leaves fire_o=1.
- Delay 0 and delay 0xFFFFFFFF: 0 behaves as 1; 0xFFFFFFFF is clamped to 0x7FFFFFFF. Assert reset mid-count: all outputs go to 0 asynchronously.
- (TIMER_SCHED_PERIODIC_EN) Arm ch3 periodic, delay 8. Required: fire re-asserts every 8 ticks after each ack and busy_o[3] stays 1. After cancel, no further fires.

Source files
------------

// File: rtl/timer_alarm_sched.sv
// rtl/timer_alarm_sched.sv - alarm slots sharing one timestamp, expired by a round-robin scanner
// Optional periodic re-arm feature: TIMER_SCHED_PERIODIC_EN
module timer_alarm_sched #(
  parameter int CH_NUM    = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      tick_i,
  input  logic                      arm_valid_i,
  output logic                      arm_ready_o,
  input  logic [$clog2(CH_NUM)-1:0] arm_ch_i,
  input  logic [CNT_WIDTH-1:0]      arm_dly_i,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic                      arm_per_i,
`endif
  input  logic [CH_NUM-1:0]         cancel_i,
  input  logic [CH_NUM-1:0]         ack_i,
  output logic [CH_NUM-1:0]         busy_o,
  output logic [CH_NUM-1:0]         fire_o,
  output logic                      irq_o,
  output logic [CNT_WIDTH-1:0]      now_o
);
  localparam int PW = $clog2(CH_NUM);
  localparam logic [CNT_WIDTH-1:0] MAX_DLY = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_now;
  logic [CNT_WIDTH-1:0] r_dl [CH_NUM];
  logic [CH_NUM-1:0]    r_busy, r_fire;
  logic                 r_irq;
  logic [PW-1:0]        r_ptr;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [CH_NUM-1:0]    r_per;
  logic [CNT_WIDTH-1:0] r_period [CH_NUM];
`endif

  logic [CNT_WIDTH-1:0] w_eff_dly, w_diff;
  logic                 w_arm_acc, w_exp;
  logic [CH_NUM-1:0]    w_arm_vec, w_exp_vec, w_exp_clr, w_busy_nxt, w_fire_nxt;

  assign arm_ready_o = ~r_busy[arm_ch_i];
  assign w_arm_acc   = arm_valid_i & arm_ready_o;

  // Clamping to half the counter range keeps the signed-difference compare wrap-safe.
  always_comb begin
    w_eff_dly = arm_dly_i;
    if (arm_dly_i == '0)
      w_eff_dly = ONE;
    else if (arm_dly_i > MAX_DLY)
      w_eff_dly = MAX_DLY;
  end

  assign w_diff = r_now - r_dl[r_ptr];
  assign w_exp  = r_busy[r_ptr] & (w_diff <= MAX_DLY) & ~cancel_i[r_ptr];

  always_comb begin
    w_arm_vec = '0;
    w_exp_vec = '0;
    if (w_arm_acc) w_arm_vec[arm_ch_i] = 1'b1;
    if (w_exp)     w_exp_vec[r_ptr]    = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
    w_exp_clr = w_exp_vec & ~r_per;
`else
    w_exp_clr = w_exp_vec;
`endif
    w_busy_nxt  = (r_busy & ~cancel_i & ~w_exp_clr) | w_arm_vec;
    w_fire_nxt  = (r_fire & ~ack_i) | w_exp_vec;
    w_state_nxt = (w_busy_nxt != '0) ? ST_SCAN : ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_now  <= '0;
      r_busy <= '0;
      r_fire <= '0;
      r_irq  <= 1'b0;
      r_ptr  <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_dl[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        r_per[i]    <= 1'b0;
        r_period[i] <= '0;
`endif
      end
    end else begin
      if (tick_i) r_now <= r_now + ONE;
      r_busy <= w_busy_nxt;
      r_fire <= w_fire_nxt;
      r_irq  <= |w_fire_nxt;
      if (r_state == ST_SCAN) r_ptr <= r_ptr + PW'(1);
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_arm_vec[i]) begin
          r_dl[i] <= r_now + w_eff_dly;
`ifdef TIMER_SCHED_PERIODIC_EN
          r_per[i]    <= arm_per_i;
          r_period[i] <= w_eff_dly;
        end else if (w_exp_vec[i] && r_per[i]) begin
          r_dl[i] <= r_dl[i] + r_period[i];
`endif
        end
      end
    end
  end

  assign busy_o = r_busy;
  assign fire_o = r_fire;
  assign irq_o  = r_irq;
  assign now_o  = r_now;
endmodule

// File: tb/tb_timer_alarm_sched.sv
// tb/tb_timer_alarm_sched.sv - directed self-checking bench for timer_alarm_sched
module tb_timer_alarm_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tick, arm_valid, arm_ready, irq;
  logic [1:0]  arm_ch;
  logic [31:0] arm_dly, now;
  logic [3:0]  cancel, ack, busy, fire;
  logic        arm_per;

  logic        n_rst_n, n_tick, n_arm_valid, n_arm_ready, n_irq;
  logic [1:0]  n_arm_ch;
  logic [7:0]  n_arm_dly, n_now;
  logic [3:0]  n_cancel, n_ack, n_busy, n_fire;

  timer_alarm_sched #(.CH_NUM(4), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick),
    .arm_valid_i(arm_valid), .arm_ready_o(arm_ready), .arm_ch_i(arm_ch), .arm_dly_i(arm_dly),
`ifdef TIMER_SCHED_PERIODIC_EN
    .arm_per_i(arm_per),
`endif
    .cancel_i(cancel), .ack_i(ack), .busy_o(busy), .fire_o(fire), .irq_o(irq), .now_o(now)
  );

  timer_alarm_sched #(.CH_NUM(4), .CNT_WIDTH(8)) dut_n (
    .clk_i(clk), .rst_n_i(n_rst_n), .tick_i(n_tick),
    .arm_valid_i(n_arm_valid), .arm_ready_o(n_arm_ready), .arm_ch_i(n_arm_ch), .arm_dly_i(n_arm_dly),
`ifdef TIMER_SCHED_PERIODIC_EN
    .arm_per_i(1'b0),
`endif
    .cancel_i(n_cancel), .ack_i(n_ack), .busy_o(n_busy), .fire_o(n_fire), .irq_o(n_irq), .now_o(n_now)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] r, d, base, lat;
  logic [31:0] dl4 [4];
  logic [31:0] rise4 [4];
  bit          seen [4];
  bit          ok, rearmed, flag;
  logic [7:0]  nr, nbase;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] val, input int lo, input int hi);
    n_chk++;
    assert (val >= 32'(lo) && val <= 32'(hi)) n_pass++;
    else $error("FAIL %s observed=%0d required=%0d..%0d", tag, val, lo, hi);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_main(input int ch, input int bound, output logic [31:0] rn, output bit got);
    got = 1'b0;
    rn  = '0;
    for (int i = 0; i < bound; i++) begin
      if (fire[ch]) begin
        got = 1'b1;
        rn  = now;
        break;
      end
      step();
    end
  endtask

  task automatic wait_nar(input int ch, input int bound, output logic [7:0] rn, output bit got);
    got = 1'b0;
    rn  = '0;
    for (int i = 0; i < bound; i++) begin
      if (n_fire[ch]) begin
        got = 1'b1;
        rn  = n_now;
        break;
      end
      step();
    end
  endtask

  // Stops on the cycle whose scan would expire slot ch (pointer on ch, deadline reached).
  task automatic find_scan(input int ch, input logic [31:0] dl, input int bound, output bit got);
    logic [31:0] diff;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      diff = now - dl;
      if (dut.r_ptr == 2'(ch) && !diff[31]) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic arm_main(input int ch, input logic [31:0] dly);
    arm_valid = 1'b1;
    arm_ch    = 2'(ch);
    arm_dly   = dly;
    step();
    arm_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; arm_valid = 1'b0; arm_ch = '0; arm_dly = '0;
    cancel = '0; ack = '0; arm_per = 1'b0;
    n_rst_n = 1'b0; n_tick = 1'b0; n_arm_valid = 1'b0; n_arm_ch = '0; n_arm_dly = '0;
    n_cancel = '0; n_ack = '0;
    step(); step();
    chk("rst_now", now, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fire", fire, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ptr", dut.r_ptr, 0);
    chk("rst_ready", arm_ready, 1);
    rst_n = 1'b1; n_rst_n = 1'b1; tick = 1'b1;

    // single one-shot, deadline 15
    for (int i = 0; i < 20 && now !== 32'd5; i++) step();
    chk("t1_now5", now, 5);
    arm_valid = 1'b1; arm_ch = 2'd0; arm_dly = 32'd10;
    #1;
    chk("t1_ready", arm_ready, 1);
    step();
    arm_valid = 1'b0;
    chk("t1_busy", busy, 4'b0001);
    wait_main(0, 40, r, ok);
    chk_rng("t1_rise_now", ok ? r : 32'hFFFF_FFFF, 16, 19);
    chk("t1_busy_fall", busy[0], 0);
    chk("t1_irq", irq, 1);
    ack = 4'b0001; step(); ack = '0;
    chk("t1_ack_fire", fire, 0);
    chk("t1_ack_irq", irq, 0);

    // four slots, delay 4, consecutive cycles, then a held-off arm of busy ch0
    for (int c = 0; c < 4; c++) begin
      dl4[c] = now + 32'd4;
      seen[c] = 1'b0;
      arm_main(c, 32'd4);
    end
    chk("t3_busy_all", busy, 4'hF);
    arm_valid = 1'b1; arm_ch = 2'd0; arm_dly = 32'd4;
    #1;
    chk("t3_ready_busy", arm_ready, 0);
    rearmed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < 4; c++)
        if (!seen[c] && fire[c]) begin
          seen[c] = 1'b1;
          rise4[c] = now;
        end
      if (seen[0] && busy[0]) rearmed = 1'b1;
      if (seen[0] && seen[1] && seen[2] && seen[3] && rearmed) break;
      step();
    end
    arm_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      lat = seen[c] ? rise4[c] - dl4[c] : 32'hFFFF_FFFF;
      chk_rng($sformatf("t3_lat_ch%0d", c), lat, 1, 4);
    end
    chk("t3_rearmed", rearmed, 1);
    cancel = 4'hF; step(); cancel = '0;
    chk("t3_cancel_busy", busy, 0);
    chk("t3_cancel_keeps_fire", fire, 4'hF);
    ack = 4'hF; step(); ack = '0;
    chk("t3_ack_fire", fire, 0);
    chk("t3_ack_irq", irq, 0);

    // cancel wins against the scan that would expire ch2
    d = now + 32'd3;
    arm_main(2, 32'd3);
    find_scan(2, d, 20, ok);
    chk("t4_found", ok, 1);
    cancel = 4'b0100; step(); cancel = '0;
    chk("t4_busy2", busy[2], 0);
    chk("t4_fire2", fire[2], 0);
    for (int i = 0; i < 6; i++) step();
    chk("t4_fire2_later", fire[2], 0);

    // same-cycle ack and re-expiry keeps fire set
    arm_main(2, 32'd2);
    wait_main(2, 20, r, ok);
    chk("t4b_first_fire", ok, 1);
    arm_valid = 1'b1; arm_ch = 2'd2; arm_dly = 32'd2;
    #1;
    chk("t4b_ready_while_fired", arm_ready, 1);
    d = now + 32'd2;
    step();
    arm_valid = 1'b0;
    chk("t4b_busy_rearm", busy[2], 1);
    chk("t4b_fire_kept_by_arm", fire[2], 1);
    find_scan(2, d, 20, ok);
    chk("t4b_found", ok, 1);
    ack = 4'b0100; step(); ack = '0;
    chk("t4b_fire_wins", fire[2], 1);
    chk("t4b_busy_done", busy[2], 0);
    ack = 4'b0100; step(); ack = '0;
    chk("t4b_fire_cleared", fire[2], 0);

    // delay 0 acts as 1; all-ones delay clamps to 0x7FFFFFFF
    base = now;
    arm_main(1, 32'd0);
    chk("t5_dl0", dut.r_dl[1], base + 32'd1);
    wait_main(1, 20, r, ok);
    chk_rng("t5_lat0", ok ? r - base : 32'hFFFF_FFFF, 2, 5);
    base = now;
    arm_main(3, 32'hFFFF_FFFF);
    chk("t5_dl_clamp", dut.r_dl[3], base + 32'h7FFF_FFFF);
    chk("t5_busy_clamp", busy[3], 1);
    step(); step();
    chk("t5_pre_rst_fire", fire, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_now", now, 0);
    chk("t5_arst_busy", busy, 0);
    chk("t5_arst_fire", fire, 0);
    chk("t5_arst_irq", irq, 0);
    step();
    rst_n = 1'b1;

`ifdef TIMER_SCHED_PERIODIC_EN
    base = now;
    arm_valid = 1'b1; arm_ch = 2'd3; arm_dly = 32'd8; arm_per = 1'b1;
    step();
    arm_valid = 1'b0; arm_per = 1'b0;
    d = base + 32'd8;
    for (int k = 0; k < 3; k++) begin
      wait_main(3, 30, r, ok);
      chk_rng($sformatf("p_lat%0d", k), ok ? r - d : 32'hFFFF_FFFF, 1, 4);
      chk($sformatf("p_busy%0d", k), busy[3], 1);
      ack = 4'b1000; step(); ack = '0;
      d = d + 32'd8;
    end
    cancel = 4'b1000; step(); cancel = '0;
    chk("p_cancel_busy", busy[3], 0);
    flag = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (fire[3]) flag = 1'b1;
      step();
    end
    chk("p_no_fire_after_cancel", flag, 0);
`endif

    // 8-bit instance: wrap at 256, deadline 253+6 = 3
    n_tick = 1'b1;
    for (int i = 0; i < 300 && n_now !== 8'd253; i++) step();
    chk("w_now253", n_now, 253);
    n_arm_valid = 1'b1; n_arm_ch = 2'd1; n_arm_dly = 8'd6;
    #1;
    chk("w_ready", n_arm_ready, 1);
    step();
    n_arm_valid = 1'b0;
    wait_nar(1, 30, nr, ok);
    chk_rng("w_rise_now", ok ? 32'(nr) : 32'hFFFF_FFFF, 4, 7);
    chk("w_busy_fall", n_busy[1], 0);
    chk("w_irq", n_irq, 1);
    n_ack = 4'b0010; step(); n_ack = '0;
    nbase = n_now;
    n_arm_valid = 1'b1; n_arm_ch = 2'd2; n_arm_dly = 8'hFF;
    step();
    n_arm_valid = 1'b0;
    wait_nar(2, 200, nr, ok);
    nr = nr - nbase;
    chk_rng("w_clamp_lat", ok ? 32'(nr) : 32'hFFFF_FFFF, 128, 131);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
